// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and helpers for the elastic pipeline stage.
//               pipe_state_t  - occupancy of the stage (EMPTY / BUSY / FULL)
//               FILL_WORD     - default debug fill word
//               fill()        - replicates a 32-bit word across a given width
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // no entry valid
    BUSY  = 2'd1,  // main entry only
    FULL  = 2'd2   // main + skid entries
  } pipe_state_t;

  localparam logic [31:0] FILL_WORD  = 32'h2A2A_2A2A;
  localparam int unsigned FILL_MAX_W = 1024;

  // Replicate 'word' LSB-first across 'width' bits; bits above width are zero.
  // Callers slice the low bits they need.
  function automatic logic [FILL_MAX_W-1:0] fill(input int unsigned width,
                                                  input logic [31:0]  word);
    logic [FILL_MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < FILL_MAX_W; i++) begin
      if (i < width) r[i] = word[i[4:0]];
    end
    return r;
  endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
// Module      : pipe_slot
// Description : One storage entry of the skid stage: a valid bit plus a
//               DATA_W payload register.
//               Priority: i_flush > i_load > i_drop.
//               PIPE_FILL_PATTERN_EN defined: flush also loads the data
//               register with the replicated fill pattern. Undefined: flush
//               only clears the valid bit.
// Ports       : CLK     clock, rising edge
//               RST     asynchronous active-high reset
//               i_flush clear valid (and fill data when enabled)
//               i_load  capture i_data and set valid
//               i_drop  clear valid, data held
//               i_data  payload to capture
//               o_valid entry holds a live beat
//               o_data  stored payload
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = 66
`ifdef PIPE_FILL_PATTERN_EN
  ,
  parameter logic [31:0] FILL_PATTERN = FILL_WORD
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_flush,
  input  logic              i_load,
  input  logic              i_drop,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

`ifdef PIPE_FILL_PATTERN_EN
  localparam logic [FILL_MAX_W-1:0] c_FILL_FULL = fill(DATA_W, FILL_PATTERN);
  localparam logic [DATA_W-1:0]     c_FILL_DATA = c_FILL_FULL[DATA_W-1:0];
`endif

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
`ifdef PIPE_FILL_PATTERN_EN
      r_data  <= c_FILL_DATA;
`endif
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_drop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule : pipe_slot
`default_nettype wire

// File: rtl/pipe_skid_register.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_register
// Description : Elastic inter-stage pipeline register with valid/ready
//               handshake and a one-entry skid buffer. In_Ready comes straight
//               from the skid valid flop, so the producer never sees a
//               combinational path from Out_Ready. Full throughput, one cycle
//               of latency. Flush empties both entries and outranks any
//               handshake in the same cycle.
//               Optional macro: PIPE_FILL_PATTERN_EN (flush loads the data
//               registers with FILL_PATTERN replicated to DATA_W).
// Ports       : CLK        clock, rising edge
//               RST        asynchronous active-high reset
//               Flush      synchronous flush of both entries
//               In_Valid   producer beat valid
//               In_Ready   stage can accept a beat (= !skid valid)
//               In_Data    producer payload
//               Out_Valid  main entry holds a live beat
//               Out_Ready  consumer accepts
//               Out_Data   main entry payload
//               Skid_Full  skid entry occupied
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_register
  import pipe_pkg::*;
#(
  parameter int          DATA_W       = 66,
  parameter logic [31:0] FILL_PATTERN = FILL_WORD
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Flush,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [DATA_W-1:0] In_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [DATA_W-1:0] Out_Data,
  output logic              Skid_Full
);

  pipe_state_t       r_state;
  pipe_state_t       w_state_nxt;

  logic              w_main_valid;
  logic [DATA_W-1:0] w_main_data;
  logic              w_skid_valid;
  logic [DATA_W-1:0] w_skid_data;

  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_main_load;
  logic              w_main_from_skid;
  logic              w_main_drop;
  logic              w_skid_load;
  logic              w_skid_drop;
  logic [DATA_W-1:0] w_main_din;

  assign In_Ready   = ~w_skid_valid;
  assign w_in_fire  = In_Valid & In_Ready;
  assign w_out_fire = w_main_valid & Out_Ready;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_main_drop      = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_drop      = 1'b0;

    case (r_state)
      EMPTY: begin
        if (w_in_fire) begin
          w_main_load = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (w_in_fire && w_out_fire) begin
          // Pass-through: replace the departing beat in place.
          w_main_load = 1'b1;
        end else if (w_in_fire) begin
          // Consumer stalled: park the new beat behind the main entry.
          w_skid_load = 1'b1;
          w_state_nxt = FULL;
        end else if (w_out_fire) begin
          w_main_drop = 1'b1;
          w_state_nxt = EMPTY;
        end
      end
      FULL: begin
        // In_Ready is low here, so only the drain side can move.
        if (w_out_fire) begin
          w_main_load      = 1'b1;
          w_main_from_skid = 1'b1;
          w_skid_drop      = 1'b1;
          w_state_nxt      = BUSY;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase

    // Flush wins over both handshakes; the slots see Flush directly and give
    // it priority over their load/drop strobes.
    if (Flush) w_state_nxt = EMPTY;
  end

  assign w_main_din = w_main_from_skid ? w_skid_data : In_Data;

  pipe_slot #(
    .DATA_W       (DATA_W)
`ifdef PIPE_FILL_PATTERN_EN
    ,
    .FILL_PATTERN (FILL_PATTERN)
`endif
  ) u_main (
    .CLK     (CLK),
    .RST     (RST),
    .i_flush (Flush),
    .i_load  (w_main_load),
    .i_drop  (w_main_drop),
    .i_data  (w_main_din),
    .o_valid (w_main_valid),
    .o_data  (w_main_data)
  );

  pipe_slot #(
    .DATA_W       (DATA_W)
`ifdef PIPE_FILL_PATTERN_EN
    ,
    .FILL_PATTERN (FILL_PATTERN)
`endif
  ) u_skid (
    .CLK     (CLK),
    .RST     (RST),
    .i_flush (Flush),
    .i_load  (w_skid_load),
    .i_drop  (w_skid_drop),
    .i_data  (In_Data),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data)
  );

  assign Out_Valid = w_main_valid;
  assign Out_Data  = w_main_data;
  assign Skid_Full = w_skid_valid;

endmodule : pipe_skid_register
`default_nettype wire

// File: tb/tb_pipe_skid_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_skid_register
// Description : Self-checking bench for pipe_skid_register. A queue holds the
//               beats the stage must contain (at most two); every cycle the
//               DUT outputs are compared against it. Directed sequences add
//               literal expectations for streaming, backpressure, flush and
//               asynchronous reset, followed by a long random valid/ready run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_register;

  localparam int DATA_W = 66;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              Flush = 1'b0;
  logic              In_Valid = 1'b0;
  logic              In_Ready;
  logic [DATA_W-1:0] In_Data = '0;
  logic              Out_Valid;
  logic              Out_Ready = 1'b0;
  logic [DATA_W-1:0] Out_Data;
  logic              Skid_Full;

  int checks = 0;
  int errors = 0;

  pipe_skid_register #(.DATA_W(DATA_W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Flush     (Flush),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .In_Data   (In_Data),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Out_Data  (Out_Data),
    .Skid_Full (Skid_Full)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: contents of the stage, oldest first ----
  logic [DATA_W-1:0] q[$];
  bit                m_in_fire, m_out_fire;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      q.delete();
    end else begin
      m_in_fire  = In_Valid && (q.size() < 2);
      m_out_fire = (q.size() > 0) && Out_Ready;
      if (Flush) begin
        q.delete();
      end else begin
        if (m_out_fire) void'(q.pop_front());
        if (m_in_fire)  q.push_back(In_Data);
      end
    end
  end

  // ---------------- per-cycle compare ---------------------------------------
  always @(negedge CLK) begin
    if (!RST) begin
      chk("m_in_ready",  In_Ready,  q.size() < 2);
      chk("m_out_valid", Out_Valid, q.size() > 0);
      chk("m_skid_full", Skid_Full, q.size() == 2);
      if (q.size() > 0) chk("m_out_data", Out_Data, q[0]);
    end
  end

  bit seen33 = 0;
  always @(negedge CLK) if (Out_Valid && Out_Data == 66'h33) seen33 = 1;

  // ---------------- stimulus helpers ----------------------------------------
  task automatic drive(input logic v, input logic [DATA_W-1:0] d,
                       input logic r, input logic f);
    In_Valid  = v;
    In_Data   = d;
    Out_Ready = r;
    Flush     = f;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [95:0]       fill96;
  logic [DATA_W-1:0] fill_exp;
  int unsigned       nd;
  logic              rdy;

  initial begin
    fill96   = {3{32'h2A2A_2A2A}};
    fill_exp = fill96[DATA_W-1:0];

    // Reset state
    tick(); tick();
    chk("rst_out_valid", Out_Valid, 1'b0);
    chk("rst_in_ready",  In_Ready,  1'b1);
    chk("rst_skid_full", Skid_Full, 1'b0);
    chk("rst_out_data",  Out_Data,  '0);
    RST = 1'b0;

    // 1. Streaming: beat i visible right after the edge that accepted it
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, DATA_W'(i), 1'b1, 1'b0);
      tick();
      chk("stream_valid", Out_Valid, 1'b1);
      chk("stream_data",  Out_Data,  DATA_W'(i));
      chk("stream_ready", In_Ready,  1'b1);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    chk("stream_drained", Out_Valid, 1'b0);

    // 2. Backpressure
    drive(1'b1, 66'h11, 1'b0, 1'b0); tick();
    chk("bp_a_data",  Out_Data, 66'h11);
    chk("bp_a_ready", In_Ready, 1'b1);
    drive(1'b1, 66'h22, 1'b0, 1'b0); tick();
    chk("bp_full",    Skid_Full, 1'b1);
    chk("bp_noready", In_Ready,  1'b0);
    chk("bp_hold_a",  Out_Data,  66'h11);
    drive(1'b0, '0, 1'b1, 1'b0); tick();
    chk("bp_b_data",  Out_Data,  66'h22);
    chk("bp_ready",   In_Ready,  1'b1);
    chk("bp_notfull", Skid_Full, 1'b0);
    tick();
    chk("bp_empty",   Out_Valid, 1'b0);

    // 3. Flush while FULL, no incoming beat
    drive(1'b1, 66'h44, 1'b0, 1'b0); tick();
    drive(1'b1, 66'h55, 1'b0, 1'b0); tick();
    chk("fl_full", Skid_Full, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1); tick();
    chk("fl_valid", Out_Valid, 1'b0);
    chk("fl_skid",  Skid_Full, 1'b0);
    chk("fl_ready", In_Ready,  1'b1);
`ifdef PIPE_FILL_PATTERN_EN
    chk("fl_fill",  Out_Data,  fill_exp);
`endif

    // 4. Flush together with in_fire of 0x33 while BUSY
    drive(1'b1, 66'h66, 1'b0, 1'b0); tick();
    drive(1'b1, 66'h33, 1'b0, 1'b1);
    chk("fl33_accepted", In_Ready, 1'b1);
    tick();
    chk("fl33_valid", Out_Valid, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    tick(); tick();
    chk("fl33_never", seen33, 1'b0);

    // 5. Asynchronous reset mid-cycle while FULL
    drive(1'b1, 66'h77, 1'b0, 1'b0); tick();
    drive(1'b1, 66'h88, 1'b0, 1'b0); tick();
    chk("ar_full", Skid_Full, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0);
    #2 RST = 1'b1;
    #1;
    chk("ar_valid", Out_Valid, 1'b0);
    chk("ar_ready", In_Ready,  1'b1);
    chk("ar_skid",  Skid_Full, 1'b0);
    chk("ar_data",  Out_Data,  '0);
    tick();
    RST = 1'b0;

    // 6. Random valid/ready; producer holds data until accepted
    nd = 1000;
    drive(1'b1, {2'(nd), 32'(nd * 7), 32'(nd)}, 1'b1, 1'b0);
    for (int c = 0; c < 10000; c++) begin
      rdy = In_Ready;
      tick();
      if (In_Valid && rdy) nd++;
      drive(1'($urandom_range(0, 1)), {2'(nd), 32'(nd * 7), 32'(nd)},
            1'($urandom_range(0, 3) != 0), 1'b0);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick(); tick(); tick();
    chk("rand_drained", Out_Valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pipe_skid_register
`default_nettype wire
